alu_responder: RTL and testbench

- Sequential responder for the 6-bit ALU operation stream: accepts operand/opcode requests over a valid/ready handshake, executes them, and returns registered results plus flags over a second valid/ready handshake.
- An internal response FIFO decouples request acceptance from response consumption.
- Sits between any stimulus or sequencer master issuing ALU operations and the result consumer.

---
 rtl/alu_responder.sv | 138 +++++++++++++
 tb/tb_alu_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : alu_responder
// Description : Valid/ready ALU responder (ADD/SUB/AND/OR). Results and flags
//               are computed when a request is accepted and queued in a
//               response FIFO. Define ALU_RSP_OVF_EN to store signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_responder #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_ovf,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam int c_TAG_LSB = WIDTH + 1;
`ifdef ALU_RSP_OVF_EN
    localparam int c_ENT_W = WIDTH + 1 + TAG_W + 1;
`else
    localparam int c_ENT_W = WIDTH + 1 + TAG_W;
`endif

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_AND = 2'd2;
    localparam logic [1:0] c_OP_OR  = 2'd3;

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [TAG_W-1:0]   r_tag;

    logic [WIDTH:0]     w_ext;
    logic [WIDTH-1:0]   w_result;
    logic               w_carry;
    logic [c_ENT_W-1:0] w_entry;
    logic [c_ENT_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;

    // Extended-width arithmetic: bit WIDTH is carry for ADD and borrow for SUB.
    always_comb begin
        w_ext = '0;
        case (req_op)
            c_OP_ADD: w_ext = {1'b0, req_a} + {1'b0, req_b};
            c_OP_SUB: w_ext = {1'b0, req_a} - {1'b0, req_b};
            c_OP_AND: w_ext = {1'b0, req_a & req_b};
            c_OP_OR:  w_ext = {1'b0, req_a | req_b};
            default:  w_ext = '0;
        endcase
    end

    assign w_result = w_ext[WIDTH-1:0];
    assign w_carry  = w_ext[WIDTH];

`ifdef ALU_RSP_OVF_EN
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        case (req_op)
            c_OP_ADD: w_ovf = (req_a[WIDTH-1] == req_b[WIDTH-1]) &&
                              (w_result[WIDTH-1] != req_a[WIDTH-1]);
            c_OP_SUB: w_ovf = (req_a[WIDTH-1] != req_b[WIDTH-1]) &&
                              (w_result[WIDTH-1] != req_a[WIDTH-1]);
            default:  w_ovf = 1'b0;
        endcase
    end

    assign w_entry = {w_ovf, r_tag, w_carry, w_result};
    assign rsp_ovf = rsp_valid & w_head[c_ENT_W-1];
`else
    assign w_entry = {r_tag, w_carry, w_result};
    assign rsp_ovf = 1'b0;
`endif

    // Both handshakes are held off while reset is asserted.
    assign rsp_valid = !rst && (r_count != '0);
    assign req_ready = !rst && ((r_count < c_FULL) || (rsp_valid && rsp_ready));
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    assign w_head    = r_mem[r_rd_ptr];
    assign rsp_data  = rsp_valid ? w_head[WIDTH-1:0] : '0;
    assign rsp_carry = rsp_valid & w_head[WIDTH];
    assign rsp_zero  = rsp_valid && (w_head[WIDTH-1:0] == '0);
    assign rsp_neg   = rsp_valid & w_head[WIDTH-1];
    assign rsp_tag   = rsp_valid ? w_head[c_TAG_LSB +: TAG_W] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tag    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                r_tag    <= r_tag + TAG_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_responder
// Description : Directed self-checking bench for alu_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_responder;

`ifdef ALU_RSP_OVF_EN
    localparam logic [31:0] c_OVF = 32'd1;
`else
    localparam logic [31:0] c_OVF = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [5:0] req_a = '0;
    logic [5:0] req_b = '0;
    logic [1:0] req_op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [5:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_neg;
    logic       rsp_ovf;
    logic [3:0] rsp_tag;

    int n_pass  = 0;
    int n_total = 0;

    alu_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .rsp_ovf   (rsp_ovf),
        .rsp_tag   (rsp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
    endtask

    task automatic chk_rsp(input string tag, input logic [5:0] d, input logic c,
                           input logic z, input logic n, input logic [3:0] t);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
        chk({tag, "_carry"}, 32'(rsp_carry), 32'(c));
        chk({tag, "_zero"},  32'(rsp_zero),  32'(z));
        chk({tag, "_neg"},   32'(rsp_neg),   32'(n));
        chk({tag, "_tag"},   32'(rsp_tag),   32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle outputs
        tick();
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_data",  32'(rsp_data),  32'd0);
        chk("post_rst_tag",   32'(rsp_tag),   32'd0);
        chk("post_rst_flags", 32'({rsp_carry, rsp_zero, rsp_neg, rsp_ovf}), 32'd0);

        // ADD -5 + 20 into empty FIFO
        drive(6'b111011, 6'b010100, 2'd0);
        tick();
        req_valid = 1'b0;
        chk_rsp("add", 6'b001111, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("add_ovf", 32'(rsp_ovf), 32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("add_popped", 32'(rsp_valid), 32'd0);

        // SUB then AND back-to-back
        drive(6'b000101, 6'b001010, 2'd1);
        tick();
        chk_rsp("sub", 6'b111011, 1'b1, 1'b0, 1'b1, 4'd1);
        drive(6'b000101, 6'b010100, 2'd2);
        tick();
        chk_rsp("and", 6'b000100, 1'b0, 1'b0, 1'b0, 4'd2);
        req_valid = 1'b0;
        tick();
        chk("and_popped", 32'(rsp_valid), 32'd0);

        // OR, then signed overflow ADD
        drive(6'b111101, 6'b110110, 2'd3);
        tick();
        chk_rsp("or", 6'b111111, 1'b0, 1'b0, 1'b1, 4'd3);
        chk("or_ovf", 32'(rsp_ovf), 32'd0);
        drive(6'b011111, 6'b000001, 2'd0);
        tick();
        chk_rsp("ovf_add", 6'b100000, 1'b0, 1'b0, 1'b1, 4'd4);
        chk("ovf_add_ovf", 32'(rsp_ovf), c_OVF);

        // Zero result with carry: -32 + -32
        drive(6'b100000, 6'b100000, 2'd0);
        tick();
        chk_rsp("zero", 6'b000000, 1'b1, 1'b1, 1'b0, 4'd5);
        chk("zero_ovf", 32'(rsp_ovf), c_OVF);
        req_valid = 1'b0;
        tick();
        chk("zero_popped", 32'(rsp_valid), 32'd0);

        // Reset so backpressure tags start at 0
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Backpressure: five requests, four accepted, head stays stable
        for (int i = 0; i < 5; i++) begin
            drive(6'(i), 6'd1, 2'd0);
            #1;
            chk("bp_ready", 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
            chk("bp_head_data", 32'(rsp_data), 32'd1);
            chk("bp_head_tag",  32'(rsp_tag),  32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_full_pop_ready", 32'(req_ready), 32'd1);
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("bp_still_full", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk("drain_valid", 32'(rsp_valid), 32'd1);
            chk("drain_tag",   32'(rsp_tag),   32'(k));
            chk("drain_data",  32'(rsp_data),  32'(k + 1));
            tick();
        end
        chk("drain_empty", 32'(rsp_valid), 32'd0);

        // Tag wrap: tags 5..15 in flow, then the 17th request wraps to 0
        for (int j = 0; j < 11; j++) begin
            drive(6'd0, 6'd0, 2'd2);
            tick();
        end
        chk("tag15", 32'(rsp_tag), 32'd15);
        drive(6'd3, 6'd4, 2'd0);
        tick();
        chk_rsp("wrap", 6'd7, 1'b0, 1'b0, 1'b0, 4'd0);
        req_valid = 1'b0;
        tick();
        chk("wrap_popped", 32'(rsp_valid), 32'd0);

        // Reset with three entries buffered
        rsp_ready = 1'b0;
        for (int m = 0; m < 3; m++) begin
            drive(6'd9, 6'(m), 2'd3);
            tick();
        end
        req_valid = 1'b0;
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_valid", 32'(rsp_valid), 32'd0);
        chk("after_rst_ready", 32'(req_ready), 32'd1);
        drive(6'd2, 6'd3, 2'd0);
        tick();
        req_valid = 1'b0;
        chk_rsp("after_rst", 6'd5, 1'b0, 1'b0, 1'b0, 4'd0);
        rsp_ready = 1'b1;
        tick();
        chk("no_stale", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
